// File: rtl/gcd_arbiter_if.sv
// Requester and gcd-unit handshake bundle for gcd_arbiter.
// slave: arbiter side; master: requesters plus gcd unit.
interface gcd_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_error;
    logic                  busy;
    logic                  gcd_start;
    logic [WIDTH-1:0]      gcd_a;
    logic [WIDTH-1:0]      gcd_b;
    logic                  gcd_done;
    logic [WIDTH-1:0]      gcd_result;

    modport slave (
        input  req_valid, req_a, req_b, gcd_done, gcd_result,
        output req_ready, rsp_valid, rsp_result, rsp_error,
        output busy, gcd_start, gcd_a, gcd_b
    );

    modport master (
        output req_valid, req_a, req_b, gcd_done, gcd_result,
        input  req_ready, rsp_valid, rsp_result, rsp_error,
        input  busy, gcd_start, gcd_a, gcd_b
    );
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one gcd unit among NREQ requesters.
// Define GCD_ARB_TIMEOUT_EN to abort ops that wait TIMEOUT cycles.
module gcd_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input logic         clk,
    input logic         reset,
    gcd_arbiter_if.slave bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || WIDTH < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("gcd_arbiter: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     gnt;
    logic [PW-1:0]     win;
    logic [PW-1:0]     nxt_ptr;
    logic              done_q;
    logic              done_edge;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [WIDTH-1:0]  rsp_result;
    logic [WIDTH-1:0]  gcd_a;
    logic [WIDTH-1:0]  gcd_b;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic              busy;
    logic              gcd_start;

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          rsp_error;
`endif

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base,
                                             input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // Scan downwards so the requester closest to ptr overwrites last.
    always_comb begin
        win = ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[rr_idx(ptr, i)]) win = rr_idx(ptr, i);
        end
    end

    always_comb begin
        sel_a = bus.req_a[int'(gnt)*WIDTH +: WIDTH];
        sel_b = bus.req_b[int'(gnt)*WIDTH +: WIDTH];
    end

    assign nxt_ptr   = (gnt == PW'(NREQ - 1)) ? '0 : gnt + 1'b1;
    assign done_edge = bus.gcd_done & ~done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt        <= '0;
            done_q     <= 1'b0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            busy       <= 1'b0;
            gcd_start  <= 1'b0;
            gcd_a      <= '0;
            gcd_b      <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
            cnt        <= '0;
            rsp_error  <= 1'b0;
`endif
        end else begin
            done_q <= bus.gcd_done;
            unique case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        gnt       <= win;
                        req_ready <= NREQ'(1) << win;
                        busy      <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    req_ready <= '0;
                    gcd_a     <= sel_a;
                    gcd_b     <= sel_b;
                    ptr       <= nxt_ptr;
                    gcd_start <= 1'b1;
                    state     <= START;
                end
                START: begin
                    gcd_start <= 1'b0;
                    state     <= WAIT;
`ifdef GCD_ARB_TIMEOUT_EN
                    cnt       <= '0;
`endif
                end
                WAIT: begin
                    // A fresh completion edge beats a simultaneous timeout.
                    if (done_edge) begin
                        rsp_valid  <= NREQ'(1) << gnt;
                        rsp_result <= bus.gcd_result;
                        state      <= RESP;
`ifdef GCD_ARB_TIMEOUT_EN
                        rsp_error  <= 1'b0;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rsp_valid  <= NREQ'(1) << gnt;
                        rsp_result <= '0;
                        rsp_error  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    rsp_valid  <= '0;
                    rsp_result <= '0;
                    busy       <= 1'b0;
                    state      <= IDLE;
`ifdef GCD_ARB_TIMEOUT_EN
                    rsp_error  <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = rsp_result;
    assign bus.busy       = busy;
    assign bus.gcd_start  = gcd_start;
    assign bus.gcd_a      = gcd_a;
    assign bus.gcd_b      = gcd_b;

`ifdef GCD_ARB_TIMEOUT_EN
    assign bus.rsp_error = rsp_error;
`else
    assign bus.rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter with a behavioural gcd unit.
// Timeout scenario runs only when GCD_ARB_TIMEOUT_EN is defined.
module tb_gcd_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;

    gcd_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bif ();

    gcd_arbiter #(
        .NREQ(NREQ),
        .WIDTH(WIDTH),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    int          n_err = 0;
    int          n_chk = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          ready_cyc = 0;
    int          drive_cyc = 0;
    int          rsp_cyc = 0;
    int          ready_gap = 0;
    bit          hang = 1'b0;
    bit          hold = 1'b0;
    int          re_n[NREQ];
    logic [31:0] re_a[NREQ];
    logic [31:0] re_b[NREQ];
    logic [31:0] ma, mb;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] gcd_f(input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural gcd unit: done rises LAT cycles after start.
    initial begin
        bif.gcd_done   = 1'b0;
        bif.gcd_result = '0;
        forever begin
            @(negedge clk);
            if (bif.gcd_start) begin
                ma = bif.gcd_a;
                mb = bif.gcd_b;
                repeat (LAT) @(negedge clk);
                if (!hang) begin
                    if (bif.gcd_done) begin
                        bif.gcd_done = 1'b0;
                        repeat (2) @(negedge clk);
                    end
                    bif.gcd_done   = 1'b1;
                    bif.gcd_result = gcd_f(ma, mb);
                    if (!hold) begin
                        @(negedge clk);
                        bif.gcd_done = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: drops accepted requests, scores responses.
    always @(negedge clk) begin
        if (bif.gcd_start) begin
            start_cyc = cyc;
            if (sb.size() > 0) begin
                check("op_a", bif.gcd_a, sb[0].a);
                check("op_b", bif.gcd_b, sb[0].b);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bif.req_ready[i]) begin
                bif.req_valid[i] = 1'b0;
                ready_cyc = cyc;
                ready_gap = cyc - rsp_cyc;
            end
        end
        if (bif.rsp_valid != 0) begin
            rsp_cyc = cyc;
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(bif.rsp_valid), 0);
            end else begin
                e_mon = sb.pop_front();
                check("rsp_id", 32'(bif.rsp_valid), 32'(1 << e_mon.id));
                check("rsp_result", bif.rsp_result, e_mon.res);
                check("rsp_error", 32'(bif.rsp_error), 32'(e_mon.err));
                check("rsp_lat", 32'(cyc - start_cyc), 32'(e_mon.lat));
                check("rsp_busy", 32'(bif.busy), 1);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bif.rsp_valid[i] && re_n[i] > 0) begin
                    re_n[i]--;
                    bif.req_a[i*WIDTH +: WIDTH] = re_a[i];
                    bif.req_b[i*WIDTH +: WIDTH] = re_b[i];
                    bif.req_valid[i] = 1'b1;
                end
            end
        end
    end

    task automatic put(input int id, input logic [31:0] a,
                       input logic [31:0] b);
        bif.req_a[id*WIDTH +: WIDTH] = a;
        bif.req_b[id*WIDTH +: WIDTH] = b;
        bif.req_valid[id] = 1'b1;
        drive_cyc = cyc;
    endtask

    task automatic expect_rsp(input int id, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res,
                              input logic err, input int lat);
        exp_t e;
        e.id  = id;
        e.a   = a;
        e.b   = b;
        e.res = res;
        e.err = err;
        e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic req(input int id, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res,
                       input int lat);
        put(id, a, b);
        expect_rsp(id, a, b, res, 1'b0, lat);
    endtask

    task automatic wait_idle(input int maxc);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            k++;
        end while ((sb.size() != 0 || bif.busy) && k < maxc);
        if (k >= maxc) check("wait_bound", 32'(sb.size()), 0);
        @(negedge clk);
    endtask

    task automatic wait_start(input int maxc);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < maxc && !seen; k++) begin
            @(negedge clk);
            if (bif.gcd_start) seen = 1'b1;
        end
        check("start_seen", 32'(seen), 1);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_req_ready"}, 32'(bif.req_ready), 0);
        check({tag, "_rsp_valid"}, 32'(bif.rsp_valid), 0);
        check({tag, "_rsp_result"}, bif.rsp_result, 0);
        check({tag, "_rsp_error"}, 32'(bif.rsp_error), 0);
        check({tag, "_busy"}, 32'(bif.busy), 0);
        check({tag, "_gcd_start"}, 32'(bif.gcd_start), 0);
        check({tag, "_gcd_a"}, bif.gcd_a, 0);
        check({tag, "_gcd_b"}, bif.gcd_b, 0);
    endtask

    initial begin
        bif.req_valid = '0;
        bif.req_a     = '0;
        bif.req_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            re_n[i] = 0;
            re_a[i] = '0;
            re_b[i] = '0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        reset = 1'b0;

        // Contention: all four in one cycle, grant order 0..3.
        @(negedge clk);
        req(0, 12, 8, 4, LAT + 1);
        req(1, 35, 14, 7, LAT + 1);
        req(2, 81, 27, 27, LAT + 1);
        req(3, 17, 5, 1, LAT + 1);
        wait_idle(200);
        check("next_grant_gap", 32'(ready_gap), 2);

        @(negedge clk);
        req(2, 60, 36, 12, LAT + 1);
        req(3, 49, 21, 7, LAT + 1);
        wait_idle(100);

        // Single request timing.
        @(negedge clk);
        req(0, 48, 18, 6, LAT + 1);
        wait_idle(50);
        check("ready_lat", 32'(ready_cyc - drive_cyc), 1);
        check("start_lat", 32'(start_cyc - drive_cyc), 2);

        // Fairness: 1 and 3 each re-assert once after their response.
        re_n[1] = 1;
        re_a[1] = 64;
        re_b[1] = 48;
        re_n[3] = 1;
        re_a[3] = 27;
        re_b[3] = 18;
        @(negedge clk);
        req(1, 100, 75, 25, LAT + 1);
        req(3, 21, 14, 7, LAT + 1);
        expect_rsp(1, 64, 48, 16, 1'b0, LAT + 1);
        expect_rsp(3, 27, 18, 9, 1'b0, LAT + 1);
        wait_idle(200);

        // Reset in WAIT for requester 2: no response, ptr back to 0.
        hang = 1'b1;
        @(negedge clk);
        put(2, 30, 12);
        wait_start(20);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_zero("midrst");
        reset = 1'b0;
        @(negedge clk);
        hang = 1'b0;
        req(0, 91, 65, 13, LAT + 1);
        req(3, 44, 33, 11, LAT + 1);
        wait_idle(100);

        // Stale done: op 2 needs a fresh rising edge.
        hold = 1'b1;
        @(negedge clk);
        req(0, 20, 8, 4, LAT + 1);
        wait_idle(50);
        hold = 1'b0;
        @(negedge clk);
        req(1, 45, 30, 15, LAT + 3);
        wait_idle(50);

`ifdef GCD_ARB_TIMEOUT_EN
        hang = 1'b1;
        @(negedge clk);
        put(0, 9, 6);
        expect_rsp(0, 9, 6, 0, 1'b1, 17);
        wait_idle(100);
        check("timeout_idle", 32'(bif.busy), 0);
        hang = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

Round-robin arbiter and sequencer that shares one `gcd` unit among `NREQ` requesters. It accepts operand pairs from requesters, drives the gcd unit's `start`/`a_in`/`b_in` handshake, waits for `done`, and routes `result` back to the granted requester. It sits between the requester ports and a single instance of the `gcd` datapath.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `WIDTH`, 32: operand and result width.
- `TIMEOUT`, 255: maximum WAIT cycles before abort. Used only with `GCD_ARB_TIMEOUT_EN`.

- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request. Held with operands until accepted.
- `req_a`  in  NREQ*WIDTH  packed operand A; slice i belongs to requester i.
- `req_b`  in  NREQ*WIDTH  packed operand B.
- `req_ready`  out  NREQ  one-hot, one-cycle accept pulse.
- `rsp_valid`  out  NREQ  one-hot, one-cycle response pulse.
- `rsp_result`  out  WIDTH  result; valid only while any `rsp_valid` bit is high.
- `rsp_error`  out  1  timeout abort flag, qualified by `rsp_valid`.
- `busy`  out  1  high in every state except IDLE.
- `gcd_start`  out  1  one-cycle start pulse to the gcd unit.
- `gcd_a`, `gcd_b`  out  WIDTH  operands. Held stable from GRANT until the op completes.
- `gcd_done`  in  1  gcd completion. Level or pulse; only its rising edge is used.
- `gcd_result`  in  WIDTH  gcd result, sampled on the `gcd_done` rising edge.

## Operation
- FSM states: IDLE, GRANT, START, WAIT, RESP.
- IDLE:
  - If any `req_valid` is high, pick the winner by round-robin starting from `ptr`, register it as `gnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - `req_ready[gnt]`=1.
  - Latch `req_a[gnt]`/`req_b[gnt]` into `gcd_a`/`gcd_b`.
  - Set `ptr` = (gnt+1) mod NREQ.
  - Go to START.
- START: `gcd_start`=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - Completion is `gcd_done & ~done_q`, where `done_q` is `gcd_done` registered every cycle.
  - On completion, capture `gcd_result` and go to RESP.
  - A `gcd_done` level held over from a previous op does not complete the op; only a fresh rising edge does.
- RESP:
  - `rsp_valid[gnt]`=1 and `rsp_result` = captured value.
  - Go to IDLE.
- `req_valid` may drop in any state. A request that drops before `req_ready` is never served.
- Requests arriving during a busy period wait; they are arbitrated in the next IDLE cycle.
- When all requesters are valid, grant order is 0,1,2,…,NREQ-1,0,…
- Reset values:
  - FSM goes to IDLE; `ptr`=0, `gnt`=0, `done_q`=0.
  - `req_ready`, `rsp_valid`, `rsp_result`, `rsp_error`, `busy`, `gcd_start`, `gcd_a`, `gcd_b` all 0.
- Reset mid-operation: the in-flight op is dropped with no response. The gcd unit's own reset is driven externally from the same source.

## Timing
- `req_valid` high in IDLE at cycle k:
  - `req_ready` pulses at k+1.
  - `gcd_start` pulses at k+2.
- `gcd_done` rises at cycle d:
  - `rsp_valid` pulses at d+1.
  - FSM is back in IDLE at d+2.
  - The next grant is at d+3 at the earliest.
- Overhead per op is 4 cycles plus gcd latency. There is no pipelining: one op in flight.
- `gcd_a`/`gcd_b` change only in GRANT or on reset.

## Configuration
- `GCD_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT` without a completion edge, go to RESP with `rsp_error`=1 and `rsp_result`=0.
  - A completion edge in the same cycle as timeout wins: `rsp_error`=0.
- Not defined:
  - WAIT waits indefinitely.
  - `rsp_error` is tied to 0 and no counter is synthesized.

## Test plan
- Single request: requester 0 sends (48,18). Expect `req_ready[0]` at k+1, `gcd_start` at k+2, `rsp_valid[0]` with `rsp_result`=6, `rsp_error`=0.
- Contention: all 4 valid in the same cycle with (12,8),(35,14),(81,27),(17,5). Expect responses in order 0,1,2,3 with 4,7,27,1. Re-issue requesters 2 and 3 only: expect order 2,3.
- Fairness: requester 1 re-asserts immediately after each response while requester 3 is valid. Grants must alternate 1,3,1,3.
- Reset mid-op: assert `reset` in WAIT for requester 2. Expect no `rsp_valid`, all outputs 0 the next cycle, `ptr`=0. Then a new request from requester 0 completes normally.
- Stale done: the gcd model holds `gcd_done` high after op 1. Op 2 must not complete until `gcd_done` falls and rises again.
- Timeout (`GCD_ARB_TIMEOUT_EN`, `TIMEOUT`=16): the gcd stub never asserts done. Expect `rsp_valid[0]` with `rsp_error`=1 and `rsp_result`=0 exactly 16 WAIT cycles after `gcd_start`, then a return to IDLE.
